// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the memory port and the busy flag of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [3:0]  a_byte_en;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic [3:0]  b_byte_en;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  logic        mem_read_en;
  logic        mem_write_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic        busy;

  modport slave (
    input  a_req, a_we, a_byte_en, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_byte_en, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_read_en, mem_write_en, mem_byte_en, mem_addr, mem_write_data,
    input  mem_read_data,
    output busy
  );

  modport master (
    output a_req, a_we, a_byte_en, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_byte_en, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_read_en, mem_write_en, mem_byte_en, mem_addr, mem_write_data,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory.
// One transaction at a time; every output is driven straight from a flop.
module mem_arbiter #(
  parameter int READ_LAT = 2
) (
  input  logic          CLOCK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  state_t      state_reg;
  logic        grant_b_reg;
  logic        last_b_reg;
  logic        we_reg;
  logic [1:0]  wait_cnt_reg;

  logic        mem_read_en_reg;
  logic        mem_write_en_reg;
  logic [3:0]  mem_byte_en_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_write_data_reg;
  logic        a_ack_reg;
  logic        b_ack_reg;
  logic [31:0] a_rdata_reg;
  logic [31:0] b_rdata_reg;
  logic        busy_reg;

  logic        pick_b;
  logic        sel_we;
  logic [3:0]  sel_byte_en;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // B wins when it is alone, or when both ask and A was served last.
  assign pick_b      = bus.b_req && (!bus.a_req || !last_b_reg);
  assign sel_we      = pick_b ? bus.b_we      : bus.a_we;
  assign sel_byte_en = pick_b ? bus.b_byte_en : bus.a_byte_en;
  assign sel_addr    = pick_b ? bus.b_addr    : bus.a_addr;
  assign sel_wdata   = pick_b ? bus.b_wdata   : bus.a_wdata;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg          <= IDLE;
      grant_b_reg        <= 1'b0;
      last_b_reg         <= 1'b1;
      we_reg             <= 1'b0;
      wait_cnt_reg       <= 2'd0;
      mem_read_en_reg    <= 1'b0;
      mem_write_en_reg   <= 1'b0;
      mem_byte_en_reg    <= 4'd0;
      mem_addr_reg       <= 32'd0;
      mem_write_data_reg <= 32'd0;
      a_ack_reg          <= 1'b0;
      b_ack_reg          <= 1'b0;
      a_rdata_reg        <= 32'd0;
      b_rdata_reg        <= 32'd0;
      busy_reg           <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle; they default low every cycle.
      mem_read_en_reg    <= 1'b0;
      mem_write_en_reg   <= 1'b0;
      mem_byte_en_reg    <= 4'd0;
      mem_addr_reg       <= 32'd0;
      mem_write_data_reg <= 32'd0;
      a_ack_reg          <= 1'b0;
      b_ack_reg          <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            grant_b_reg <= pick_b;
            last_b_reg  <= pick_b;
            we_reg      <= sel_we;
            busy_reg    <= 1'b1;
            if (sel_byte_en == 4'd0) begin
              state_reg <= ACK;
              a_ack_reg <= !pick_b;
              b_ack_reg <= pick_b;
            end else begin
              // The issue-cycle outputs are the latched request itself.
              state_reg          <= ISSUE;
              mem_read_en_reg    <= !sel_we;
              mem_write_en_reg   <= sel_we;
              mem_byte_en_reg    <= sel_byte_en;
              mem_addr_reg       <= sel_addr;
              mem_write_data_reg <= sel_wdata;
            end
          end
        end

        ISSUE: begin
          if (we_reg) begin
            state_reg <= ACK;
            a_ack_reg <= !grant_b_reg;
            b_ack_reg <= grant_b_reg;
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= 2'd0;
          end
        end

        WAIT: begin
          if (wait_cnt_reg == WAIT_LAST) begin
            state_reg <= ACK;
            a_ack_reg <= !grant_b_reg;
            b_ack_reg <= grant_b_reg;
            if (grant_b_reg) begin
              b_rdata_reg <= bus.mem_read_data;
            end else begin
              a_rdata_reg <= bus.mem_read_data;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end

        ACK: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read_en    = mem_read_en_reg;
  assign bus.mem_write_en   = mem_write_en_reg;
  assign bus.mem_byte_en    = mem_byte_en_reg;
  assign bus.mem_addr       = mem_addr_reg;
  assign bus.mem_write_data = mem_write_data_reg;
  assign bus.a_ack          = a_ack_reg;
  assign bus.b_ack          = b_ack_reg;
  assign bus.a_rdata        = a_rdata_reg;
  assign bus.b_rdata        = b_rdata_reg;
  assign bus.busy           = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when driven
// and retired against memory strobes and acks; a small memory model returns read data.
module tb_mem_arbiter;

  localparam int READ_LAT = 2;

  typedef struct {
    bit          port_b;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic CLOCK;
  logic RESET;
  mem_arbiter_if bus ();

  mem_arbiter #(.READ_LAT(READ_LAT)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 0;
  txn_t        exp_q[$];
  txn_t        pend_a[$];
  txn_t        pend_b[$];
  logic [31:0] sh_a = 32'd0;
  logic [31:0] sh_b = 32'd0;
  bit          strobe_seen = 0;
  int          strobe_cyc  = 0;
  txn_t        mh;
  int          rd_cd = 0;
  logic [31:0] rd_addr = 32'd0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] addr);
    if (addr == 32'h40) return 32'h12345678;
    return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ 16'hC3C3};
  endfunction

  function automatic txn_t mk(input bit pb, input bit we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.port_b = pb; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Memory answers exactly READ_LAT cycles after the read strobe, garbage otherwise.
  always @(negedge CLOCK) begin
    if (RESET) begin
      rd_cd <= 0;
      bus.mem_read_data <= 32'hBAD0BAD0;
    end else begin
      bus.mem_read_data <= (rd_cd == 1) ? rd_model(rd_addr) : 32'hBAD0BAD0;
      rd_cd   <= bus.mem_read_en ? READ_LAT : ((rd_cd > 0) ? rd_cd - 1 : 0);
      rd_addr <= bus.mem_read_en ? bus.mem_addr : rd_addr;
    end
  end

  always @(negedge CLOCK) begin
    if (mon_en) begin
      if (bus.mem_read_en || bus.mem_write_en) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_strobe", 1, 0);
        end else begin
          mh = exp_q[0];
          check_eq("strobe_kind", {bus.mem_write_en, bus.mem_read_en}, mh.we ? 2'b10 : 2'b01);
          check_eq("strobe_addr", bus.mem_addr, mh.addr);
          check_eq("strobe_be", bus.mem_byte_en, mh.be);
          check_eq("strobe_wdata", bus.mem_write_data, mh.wdata);
        end
        strobe_seen = 1;
        strobe_cyc  = cyc;
      end else begin
        check_eq("mem_idle", {bus.mem_byte_en, bus.mem_addr | bus.mem_write_data}, 0);
      end
      if (bus.a_ack || bus.b_ack) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_ack", {bus.a_ack, bus.b_ack}, 0);
        end else begin
          mh = exp_q.pop_front();
          check_eq("ack_port", {bus.a_ack, bus.b_ack}, mh.port_b ? 2'b01 : 2'b10);
          check_eq("ack_strobe", strobe_seen, mh.be != 4'd0);
          if (strobe_seen)
            check_eq("ack_gap", cyc - strobe_cyc, mh.we ? 1 : 1 + READ_LAT);
          if (!mh.we && mh.be != 4'd0) begin
            if (mh.port_b) sh_b = rd_model(mh.addr);
            else           sh_a = rd_model(mh.addr);
          end
          $display("txn port=%s we=%0d be=%h addr=%h wdata=%h rdata=%h cyc=%0d",
                   mh.port_b ? "B" : "A", mh.we, mh.be, mh.addr, mh.wdata,
                   mh.port_b ? bus.b_rdata : bus.a_rdata, cyc);
        end
        strobe_seen = 0;
      end
      check_eq("a_rdata", bus.a_rdata, sh_a);
      check_eq("b_rdata", bus.b_rdata, sh_b);
    end
  end

  task automatic present(input txn_t t);
    if (t.port_b) begin
      bus.b_req = 1'b1; bus.b_we = t.we; bus.b_byte_en = t.be;
      bus.b_addr = t.addr; bus.b_wdata = t.wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = t.we; bus.a_byte_en = t.be;
      bus.a_addr = t.addr; bus.a_wdata = t.wdata;
    end
  endtask

  task automatic drop(input bit pb);
    if (pb) begin
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_byte_en = 4'd0;
      bus.b_addr = 32'd0; bus.b_wdata = 32'd0;
    end else begin
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_byte_en = 4'd0;
      bus.a_addr = 32'd0; bus.a_wdata = 32'd0;
    end
  endtask

  // Single uncontended transaction from IDLE; checks the ack cycle relative to the request.
  task automatic run_txn(input txn_t t, input int exp_lat);
    bit got;
    got = 0;
    exp_q.push_back(t);
    @(posedge CLOCK); #1;
    present(t);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLOCK);
      if (k == 0) check_eq("busy_pre", bus.busy, 0);
      if (k == 1) check_eq("busy_run", bus.busy, 1);
      if (t.port_b ? bus.b_ack : bus.a_ack) begin
        got = 1;
        check_eq("ack_latency", k, exp_lat);
      end
    end
    if (!got) check_eq("ack_timeout", 0, 1);
    @(posedge CLOCK); #1;
    drop(t.port_b);
    @(negedge CLOCK);
    check_eq("busy_done", bus.busy, 0);
  endtask

  // Both ports work through their pending lists, holding req across acks.
  task automatic run_pending();
    bit ga, gb;
    @(posedge CLOCK); #1;
    if (pend_a.size() != 0) present(pend_a[0]);
    if (pend_b.size() != 0) present(pend_b[0]);
    for (int k = 0; k < 200 && (pend_a.size() != 0 || pend_b.size() != 0); k++) begin
      @(negedge CLOCK);
      ga = bus.a_ack;
      gb = bus.b_ack;
      @(posedge CLOCK); #1;
      if (ga && pend_a.size() != 0) begin
        void'(pend_a.pop_front());
        if (pend_a.size() != 0) present(pend_a[0]); else drop(1'b0);
      end
      if (gb && pend_b.size() != 0) begin
        void'(pend_b.pop_front());
        if (pend_b.size() != 0) present(pend_b[0]); else drop(1'b1);
      end
    end
    if (pend_a.size() != 0 || pend_b.size() != 0) begin
      check_eq("pend_timeout", 0, 1);
      pend_a.delete();
      pend_b.delete();
      drop(1'b0);
      drop(1'b1);
    end
  endtask

  txn_t t;

  initial begin
    RESET = 1'b1;
    drop(1'b0);
    drop(1'b1);
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_acks", {bus.a_ack, bus.b_ack}, 0);
    check_eq("rst_mem", {bus.mem_read_en, bus.mem_write_en, bus.mem_byte_en,
                         bus.mem_addr | bus.mem_write_data}, 0);
    check_eq("rst_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    @(posedge CLOCK); #1;
    RESET  = 1'b0;
    mon_en = 1;

    // Contention from reset: A first, then alternating.
    pend_a.push_back(mk(0, 1, 4'hF, 32'h200, 32'hA1A1A1A1));
    pend_a.push_back(mk(0, 0, 4'hF, 32'h204, 32'h0));
    pend_b.push_back(mk(1, 0, 4'hF, 32'h300, 32'h77));
    pend_b.push_back(mk(1, 1, 4'b0110, 32'h301, 32'hB2B2B2B2));
    exp_q.push_back(pend_a[0]);
    exp_q.push_back(pend_b[0]);
    exp_q.push_back(pend_a[1]);
    exp_q.push_back(pend_b[1]);
    run_pending();
    @(negedge CLOCK);
    check_eq("rr_drained", exp_q.size(), 0);

    run_txn(mk(0, 1, 4'hF, 32'h100, 32'hDEADBEEF), 2);
    run_txn(mk(1, 0, 4'hF, 32'h40, 32'h0), 2 + READ_LAT);
    check_eq("b_rdata_word", bus.b_rdata, 32'h12345678);
    run_txn(mk(0, 0, 4'b0011, 32'h106, 32'h5555), 2 + READ_LAT);
    run_txn(mk(0, 0, 4'h0, 32'h108, 32'h0), 1);
    check_eq("noop_a_rdata", bus.a_rdata, rd_model(32'h106));
    run_txn(mk(1, 1, 4'h0, 32'h44, 32'h99), 1);
    run_txn(mk(1, 1, 4'b1000, 32'h3, 32'hCAFEF00D), 2);
    check_eq("wr_b_rdata_hold", bus.b_rdata, 32'h12345678);

    // A served alone last, so B wins the next contention.
    run_txn(mk(0, 1, 4'hF, 32'h500, 32'h11112222), 2);
    pend_a.push_back(mk(0, 0, 4'hF, 32'h504, 32'h0));
    pend_b.push_back(mk(1, 1, 4'hF, 32'h600, 32'h33334444));
    exp_q.push_back(pend_b[0]);
    exp_q.push_back(pend_a[0]);
    run_pending();

    // Reset in the middle of a B read abandons it.
    t = mk(1, 0, 4'hF, 32'h80, 32'h0);
    exp_q.push_back(t);
    @(posedge CLOCK); #1;
    present(t);
    @(negedge CLOCK);
    @(negedge CLOCK);
    check_eq("rst_rd_issue", bus.mem_read_en, 1);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    drop(1'b1);
    @(negedge CLOCK);
    check_eq("rst_rd_wait", bus.busy, 1);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    exp_q.delete();
    strobe_seen = 0;
    sh_a = 32'd0;
    sh_b = 32'd0;
    @(negedge CLOCK);
    check_eq("rst_mid_busy", bus.busy, 0);
    check_eq("rst_mid_outs", {bus.a_ack, bus.b_ack, bus.mem_read_en, bus.mem_write_en,
                              bus.mem_byte_en}, 0);
    check_eq("rst_mid_rdata", {bus.a_rdata, bus.b_rdata}, 0);
    repeat (4) begin
      @(negedge CLOCK);
      check_eq("rst_no_b_ack", bus.b_ack, 0);
    end

    pend_a.push_back(mk(0, 1, 4'hF, 32'h700, 32'h55667788));
    pend_b.push_back(mk(1, 0, 4'hF, 32'h800, 32'h0));
    exp_q.push_back(pend_a[0]);
    exp_q.push_back(pend_b[0]);
    run_pending();

    repeat (3) @(negedge CLOCK);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_LAT, default 2, memory read latency in cycles (legal 1..4).
REQ-002 CLOCK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  requester A (CPU data port) transaction request; held until a_ack.
REQ-005 a_we  input  1  A: 1 = write, 0 = read.
REQ-006 a_byte_en  input  4  A byte lanes.
REQ-007 a_addr  input  32  A byte address.
REQ-008 a_wdata  input  32  A write data.
REQ-009 a_ack  output  1  A one-cycle completion pulse.
REQ-010 a_rdata  output  32  A read data, valid in the a_ack cycle of a read.
REQ-011 b_req, b_we, b_byte_en, b_addr, b_wdata, b_ack, b_rdata: requester B (debug/loader port), same directions, widths and meanings as A.
REQ-012 mem_read_en  output  1  memory read strobe.
REQ-013 mem_write_en  output  1  memory write strobe.
REQ-014 mem_byte_en  output  4  memory byte lanes.
REQ-015 mem_addr  output  32  memory address.
REQ-016 mem_write_data  output  32  memory write data.
REQ-017 mem_read_data  input  32  memory read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, ACK; all outputs registered.
REQ-020 Requests are sampled only in IDLE; req during ISSUE, WAIT or ACK is ignored.
REQ-021 IDLE with exactly one req high: grant that requester, latch its we/byte_en/addr/wdata, go to ISSUE.
REQ-022 IDLE with both req high: grant the requester not granted most recently; the round-robin pointer updates on every grant.
REQ-023 ISSUE (exactly one cycle): mem_addr/mem_byte_en/mem_write_data = latched values; mem_write_en = we; mem_read_en = !we.
REQ-024 Outside ISSUE, all mem_* outputs are 0.
REQ-025 Write: ISSUE -> ACK; requester sampled in IDLE at cycle N gets ack at N+2; back in IDLE at N+3.
REQ-026 Read: ISSUE -> WAIT for READ_LAT cycles; mem_read_data is registered at the end of cycle N+1+READ_LAT; ACK in cycle N+2+READ_LAT.
REQ-027 Loads: the arbiter returns the full 32-bit word; lane extraction and sign extension are the requester's job.
REQ-028 ACK: the granted requester's ack is high for exactly one cycle; the other requester's ack stays 0; next state IDLE.
REQ-029 x_rdata changes only on a read ack to that port and holds its value otherwise; write acks leave it unchanged.
REQ-030 A request with byte_en = 4'b0000 is a no-op: IDLE -> ACK directly, with no mem strobe; a read no-op leaves rdata unchanged.
REQ-031 Misaligned addresses pass through unmodified; no alignment checks are performed.
REQ-032 A requester may keep req high after its ack to start a new transaction; that request is sampled in the following IDLE cycle under round-robin rules.

Reset
REQ-033 RESET has priority over all other conditions.
REQ-034 On RESET:
- state = IDLE; busy = 0.
- All mem_* outputs = 0; a_ack = b_ack = 0; a_rdata = b_rdata = 0.
- Round-robin pointer set so that A wins the first contention.
REQ-035 RESET mid-transaction abandons the transaction: no ack is ever issued for it, and any in-flight read data is discarded.

Verification
REQ-036 A write (addr 0x100, data 0xDEADBEEF, be 4'hF) sampled at cycle N -> mem_write_en = 1 with those values at N+1, a_ack at N+2, busy low at N+3.
REQ-037 B read (addr 0x40), READ_LAT = 2, memory returns 0x12345678 during N+3 -> b_ack and b_rdata = 0x12345678 at N+4; a_ack stays 0.
REQ-038 A and B both holding req from reset -> grants alternate A, B, A, B across four transactions.
REQ-039 A read with be = 4'b0000 -> no mem strobe at any cycle, a_ack at N+1, a_rdata unchanged.
REQ-040 RESET asserted during WAIT of a B read -> next cycle: IDLE, all outputs 0, no b_ack; a subsequent contended request is granted to A.
